reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter_pkg.sv | 18 +
 rtl/reg_wb_arbiter.sv | 117 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file parameters: word type, write-port opcode and arbiter defaults.
// Imported by reg_wb_arbiter and by the register file instantiated alongside it.
package reg_wb_arbiter_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef logic [WORD_SIZE-1:0] word;

  typedef enum logic {
    NO_REG_OP      = 1'b0,
    WRITE_REG_DATA = 1'b1
  } reg_file_op_t;

  // EX may lose this many consecutive arbitrations before it is forced through.
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned STARVE_CNT_W         = 4;

endpackage

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: picks EX or MEM into a one-entry output stage feeding the register file.
// Build option REG_WB_FWD_EN: forward the staged result to readers instead of raising raw_stall.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,

  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [4:0]   ex_rd,
  input  word          ex_data,

  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [4:0]   mem_rd,
  input  word          mem_data,

  output reg_file_op_t wb_op,
  output logic [4:0]   wb_rd,
  output word          wb_data,

  input  logic [4:0]   q_rs1,
  input  logic [4:0]   q_rs2,
  output logic         fwd_hit1,
  output logic         fwd_hit2,
  output word          fwd_data1,
  output word          fwd_data2,
  output logic         raw_stall
);

  localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [4:0]              wb_rd_q, wb_rd_d;
  word                     wb_data_q, wb_data_d;

  logic       grant_ex, grant_mem;
  logic [4:0] sel_rd;
  word        sel_data;
  logic       match1, match2;

  // MEM normally wins ties; EX wins once it has lost Limit times in a row.
  always_comb begin
    grant_ex  = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (ex_valid && mem_valid) begin
        if (starve_cnt_q == Limit) grant_ex = 1'b1;
        else                       grant_mem = 1'b1;
      end else begin
        grant_ex  = ex_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign ex_ready  = grant_ex;
  assign mem_ready = grant_mem;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ex_valid || ex_ready) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != Limit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // A transfer to x0 is accepted but never staged as a write.
  always_comb begin
    sel_rd     = grant_ex ? ex_rd   : mem_rd;
    sel_data   = grant_ex ? ex_data : mem_data;
    wb_valid_d = (grant_ex || grant_mem) && (sel_rd != 5'd0);
    wb_rd_d    = wb_valid_d ? sel_rd   : 5'd0;
    wb_data_d  = wb_valid_d ? sel_data : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign wb_op   = wb_valid_q ? WRITE_REG_DATA : NO_REG_OP;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

  assign match1 = wb_valid_q && (wb_rd_q == q_rs1) && (q_rs1 != 5'd0);
  assign match2 = wb_valid_q && (wb_rd_q == q_rs2) && (q_rs2 != 5'd0);

`ifdef REG_WB_FWD_EN
  assign fwd_hit1  = match1;
  assign fwd_hit2  = match2;
  assign fwd_data1 = match1 ? wb_data_q : '0;
  assign fwd_data2 = match2 ? wb_data_q : '0;
  assign raw_stall = 1'b0;
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
  assign raw_stall = match1 || match2;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: arbitration, starvation, x0 handling, forwarding, reset.
// Expected forwarding behaviour follows REG_WB_FWD_EN as defined for the build.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         ex_valid, mem_valid;
  logic         ex_ready, mem_ready;
  logic [4:0]   ex_rd, mem_rd;
  word          ex_data, mem_data;
  reg_file_op_t wb_op;
  logic [4:0]   wb_rd;
  word          wb_data;
  logic [4:0]   q_rs1, q_rs2;
  logic         fwd_hit1, fwd_hit2, raw_stall;
  word          fwd_data1, fwd_data2;

  int total = 0;
  int bad   = 0;

  reg_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rd     (ex_rd),
    .ex_data   (ex_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_op     (wb_op),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .raw_stall (raw_stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic ev, input logic [4:0] erd, input word ed,
                        input logic mv, input logic [4:0] mrd, input word md);
    ex_valid  = ev;
    ex_rd     = erd;
    ex_data   = ed;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    #1;
  endtask

  // Both requesters held valid: MEM for n_mem cycles, then one EX grant.
  task automatic run_both(input string tag, input int n_mem);
    logic exp_ex;
    set_in(1'b1, 5'd3, 32'hE000_0003, 1'b1, 5'd4, 32'hD000_0004);
    for (int k = 0; k <= n_mem; k++) begin
      exp_ex = (k == n_mem);
      check({tag, " ex_ready"}, 32'(ex_ready), 32'(exp_ex));
      check({tag, " mem_ready"}, 32'(mem_ready), 32'(!exp_ex));
      tick();
      check({tag, " wb_rd"}, 32'(wb_rd), exp_ex ? 32'd3 : 32'd4);
      check({tag, " wb_data"}, wb_data, exp_ex ? 32'hE000_0003 : 32'hD000_0004);
    end
  endtask

  initial begin
    reset = 1'b1;
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    set_in(1'b1, 5'd3, 32'hE000_0003, 1'b1, 5'd4, 32'hD000_0004);

    // Requests pending during reset are not accepted.
    repeat (2) tick();
    check("rst ex_ready", 32'(ex_ready), 32'd0);
    check("rst mem_ready", 32'(mem_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post-rst wb_op", 32'(wb_op), 32'(NO_REG_OP));
    check("post-rst wb_rd", 32'(wb_rd), 32'd0);
    check("post-rst wb_data", wb_data, 32'd0);
    check("post-rst fwd_hit1", 32'(fwd_hit1), 32'd0);
    check("post-rst fwd_hit2", 32'(fwd_hit2), 32'd0);
    check("post-rst fwd_data1", fwd_data1, 32'd0);
    check("post-rst fwd_data2", fwd_data2, 32'd0);
    check("post-rst raw_stall", 32'(raw_stall), 32'd0);

    // Starvation: 4 MEM, 1 EX, then the counter restarts.
    run_both("starve1", 4);
    run_both("starve2", 4);

    // EX dropping its request clears the starvation count.
    for (int k = 0; k < 2; k++) begin
      check("pre-drop mem_ready", 32'(mem_ready), 32'd1);
      tick();
    end
    set_in(1'b0, 5'd3, 32'hE000_0003, 1'b1, 5'd4, 32'hD000_0004);
    check("drop ex_ready", 32'(ex_ready), 32'd0);
    check("drop mem_ready", 32'(mem_ready), 32'd1);
    tick();
    run_both("after-drop", 4);

    // Idle: no grants, output stage empties.
    set_in(1'b0, 5'd3, 32'h0, 1'b0, 5'd4, 32'h0);
    check("idle ex_ready", 32'(ex_ready), 32'd0);
    check("idle mem_ready", 32'(mem_ready), 32'd0);
    tick();
    check("idle wb_op", 32'(wb_op), 32'(NO_REG_OP));

    // EX alone.
    set_in(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'h0);
    check("exonly ex_ready", 32'(ex_ready), 32'd1);
    check("exonly mem_ready", 32'(mem_ready), 32'd0);
    tick();
    check("exonly wb_op", 32'(wb_op), 32'(WRITE_REG_DATA));
    check("exonly wb_rd", 32'(wb_rd), 32'd5);
    check("exonly wb_data", wb_data, 32'hA5A5_0001);

    // Write to x0 completes but stages nothing.
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    check("x0 mem_ready", 32'(mem_ready), 32'd1);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("x0 wb_op", 32'(wb_op), 32'(NO_REG_OP));
    check("x0 fwd_hit1", 32'(fwd_hit1), 32'd0);
    check("x0 raw_stall", 32'(raw_stall), 32'd0);

    // Forwarding / RAW query on the staged result.
    set_in(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
    tick();
    q_rs1 = 5'd7;
    q_rs2 = 5'd7;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef REG_WB_FWD_EN
    check("fwd hit1", 32'(fwd_hit1), 32'd1);
    check("fwd hit2", 32'(fwd_hit2), 32'd1);
    check("fwd data1", fwd_data1, 32'h1234_5678);
    check("fwd data2", fwd_data2, 32'h1234_5678);
    check("fwd raw_stall", 32'(raw_stall), 32'd0);
`else
    check("nofwd hit1", 32'(fwd_hit1), 32'd0);
    check("nofwd hit2", 32'(fwd_hit2), 32'd0);
    check("nofwd data1", fwd_data1, 32'd0);
    check("nofwd raw_stall", 32'(raw_stall), 32'd1);
`endif
    q_rs1 = 5'd6;
    q_rs2 = 5'd0;
    #1;
    check("nomatch hit1", 32'(fwd_hit1), 32'd0);
    check("nomatch raw_stall", 32'(raw_stall), 32'd0);
    q_rs1 = 5'd0;

    // Reset with a staged write and a partly built starvation count.
    set_in(1'b1, 5'd3, 32'hE000_0003, 1'b1, 5'd4, 32'hD000_0004);
    for (int k = 0; k < 3; k++) begin
      check("pre-rst mem_ready", 32'(mem_ready), 32'd1);
      tick();
    end
    check("pre-rst wb_op", 32'(wb_op), 32'(WRITE_REG_DATA));
    reset = 1'b1;
    #1;
    check("mid-rst ex_ready", 32'(ex_ready), 32'd0);
    check("mid-rst mem_ready", 32'(mem_ready), 32'd0);
    tick();
    check("mid-rst wb_op", 32'(wb_op), 32'(NO_REG_OP));
    check("mid-rst wb_rd", 32'(wb_rd), 32'd0);
    reset = 1'b0;
    #1;
    run_both("after-rst", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
